// File: rtl/phase_filter.sv
// phase_filter: per-transducer phase offset and intensity mask applied to the
// modulator stream. Two 9-bit tables (offset + mask) are double-buffered; the
// active bank is read along the stream while the shadow bank takes config writes.
// A requested bank exchange waits for an idle gap, so no frame ever mixes banks.
module phase_filter #(
   parameter int DEPTH = 249
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       DIN_VALID,
   input  logic [7:0] INTENSITY_IN,
   input  logic [7:0] PHASE_IN,
   input  logic       CFG_WE,
   input  logic [7:0] CFG_ADDR,
   input  logic [8:0] CFG_WDATA,
   input  logic       CFG_SWAP,
   output logic [7:0] INTENSITY_OUT,
   output logic [7:0] PHASE_OUT,
   output logic       DOUT_VALID,
   output logic       SWAP_DONE
);

   localparam logic [7:0] LAST_IDX = 8'(DEPTH - 1);
   localparam logic [8:0] DEPTH_W  = 9'(DEPTH);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t     r_state;
   state_t     w_state_next;
   logic [7:0] r_idx;
   logic       r_active;
   logic       r_swap_pend;
   logic       r_swap_done;
   logic       w_swap_fire;
   logic       w_last;
   logic       w_addr_ok;
   logic [1:0] w_we;
   logic [8:0] w_rd_word [2];
   logic [8:0] w_word;

   // stage 1: input capture alongside the table read
   logic       r_v1;
   logic       r_sel1;
   logic [7:0] r_int1;
   logic [7:0] r_ph1;

   // stage 2: output registers
   logic       r_v2;
   logic [7:0] r_int2;
   logic [7:0] r_ph2;

   assign w_last    = (r_idx == LAST_IDX);
   assign w_addr_ok = ({1'b0, CFG_ADDR} < DEPTH_W);

   // Frame state register
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Frame next-state: a frame starts on the first valid and ends after the last index
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: if (DIN_VALID && (DEPTH > 1)) w_state_next = S_RUN;
         S_RUN:  if (DIN_VALID && w_last)      w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // Swap is only allowed in a true idle gap between frames, never at a frame start
   always_comb begin
      w_swap_fire = 1'b0;
      if ((r_state == S_IDLE) && r_swap_pend && !DIN_VALID) begin
         w_swap_fire = 1'b1;
      end
   end

   // Index counter, sticky swap request, active-bank select and completion pulse
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_idx       <= 8'd0;
         r_active    <= 1'b0;
         r_swap_pend <= 1'b0;
         r_swap_done <= 1'b0;
      end else begin
         if (DIN_VALID) begin
            r_idx <= w_last ? 8'd0 : r_idx + 8'd1;
         end
         // a request arriving in the swap cycle itself stays pending for the next gap
         r_swap_pend <= (r_swap_pend & ~w_swap_fire) | CFG_SWAP;
         if (w_swap_fire) begin
            r_active <= ~r_active;
         end
         r_swap_done <= w_swap_fire;
      end
   end

   // Two table banks; writes go to whichever bank is shadow before any swap this cycle
   for (genvar gi = 0; gi < 2; gi++) begin : g_bank
      logic [8:0] r_mem [DEPTH] = '{default: 9'h000};
      logic [8:0] r_rd;

      assign w_we[gi] = CFG_WE & ~RST & w_addr_ok & (r_active != 1'(gi));

      // Block RAM: config write port plus registered stream read port
      always_ff @(posedge CLK) begin
         if (w_we[gi]) begin
            r_mem[CFG_ADDR] <= CFG_WDATA;
         end
         if (DIN_VALID) begin
            r_rd <= r_mem[r_idx];
         end
      end

      assign w_rd_word[gi] = r_rd;
   end

   // Stage 1: register stream sample and remember which bank it was read from
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_v1 <= 1'b0;
      end else begin
         r_v1 <= DIN_VALID;
      end
      if (DIN_VALID) begin
         r_int1 <= INTENSITY_IN;
         r_ph1  <= PHASE_IN;
         r_sel1 <= r_active;
      end
   end

   assign w_word = r_sel1 ? w_rd_word[1] : w_rd_word[0];

   // Stage 2: apply mask and wrapping phase offset
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_v2   <= 1'b0;
         r_int2 <= 8'd0;
         r_ph2  <= 8'd0;
      end else begin
         r_v2 <= r_v1;
         if (r_v1) begin
            r_int2 <= w_word[8] ? 8'd0 : r_int1;
            r_ph2  <= r_ph1 + w_word[7:0];
         end
      end
   end

   assign INTENSITY_OUT = r_int2;
   assign PHASE_OUT     = r_ph2;
   assign DOUT_VALID    = r_v2;
   assign SWAP_DONE     = r_swap_done;

endmodule

// File: tb/tb_phase_filter.sv
// Directed bench for phase_filter: reset, pass-through frame, bank swap with
// offset wrap and mask, mid-frame swap request, frame-start hold-off, gaps,
// mid-frame reset and out-of-range config writes.
module tb_phase_filter;

   localparam int DEPTH = 249;

   logic       clk;
   logic       rst;
   logic       din_valid;
   logic [7:0] intensity_in;
   logic [7:0] phase_in;
   logic       cfg_we;
   logic [7:0] cfg_addr;
   logic [8:0] cfg_wdata;
   logic       cfg_swap;
   logic [7:0] intensity_out;
   logic [7:0] phase_out;
   logic       dout_valid;
   logic       swap_done;

   int n_vec;
   int n_err;
   int n_step;

   // expected contents of each bank as written by this bench
   logic [7:0] off0 [256];
   logic [7:0] off1 [256];
   logic       msk0 [256];
   logic       msk1 [256];

   // expectation for the sample applied on the previous step
   logic       p_v;
   logic [7:0] p_i;
   logic [7:0] p_p;

   phase_filter #(.DEPTH(DEPTH)) dut (
      .CLK           (clk),
      .RST           (rst),
      .DIN_VALID     (din_valid),
      .INTENSITY_IN  (intensity_in),
      .PHASE_IN      (phase_in),
      .CFG_WE        (cfg_we),
      .CFG_ADDR      (cfg_addr),
      .CFG_WDATA     (cfg_wdata),
      .CFG_SWAP      (cfg_swap),
      .INTENSITY_OUT (intensity_out),
      .PHASE_OUT     (phase_out),
      .DOUT_VALID    (dout_valid),
      .SWAP_DONE     (swap_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s step %0d: observed %02h expected %02h", tag, n_step, obs, expv);
      end
   endtask

   // One clock: outputs now reflect the sample applied one step earlier.
   task automatic step(input logic [7:0] ei, input logic [7:0] ep, input logic esd);
      logic       ev;
      logic [7:0] xi;
      logic [7:0] xp;
      @(posedge clk);
      #1;
      if (rst) begin
         ev = 1'b0; xi = 8'h00; xp = 8'h00;
      end else begin
         ev = p_v; xi = p_i; xp = p_p;
      end
      check("dout_valid", {7'd0, dout_valid}, {7'd0, ev});
      check("swap_done", {7'd0, swap_done}, {7'd0, esd & ~rst});
      if (ev || rst) begin
         check("intensity_out", intensity_out, xi);
         check("phase_out", phase_out, xp);
      end
      p_v = din_valid & ~rst;
      p_i = ei;
      p_p = ep;
      n_step++;
   endtask

   task automatic idle(input int n);
      din_valid = 1'b0;
      for (int k = 0; k < n; k++) step(8'h00, 8'h00, 1'b0);
   endtask

   task automatic cfg_write(input logic [7:0] a, input logic [8:0] d, input logic esd);
      cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
      step(8'h00, 8'h00, esd);
      cfg_we = 1'b0;
   endtask

   // Streams indices 0..n_idx-1; ph_fixed<0 means phase = index.
   task automatic run_frame(input int bank, input logic [7:0] ii, input int ph_fixed,
                            input int gap_every, input int swap_at, input int n_idx);
      logic [7:0] p;
      logic [7:0] off;
      logic [7:0] e_i;
      logic       m;
      for (int i = 0; i < n_idx; i++) begin
         p   = (ph_fixed < 0) ? 8'(i) : 8'(ph_fixed);
         off = (bank == 1) ? off1[i] : off0[i];
         m   = (bank == 1) ? msk1[i] : msk0[i];
         e_i = m ? 8'h00 : ii;
         din_valid = 1'b1; intensity_in = ii; phase_in = p;
         cfg_swap = (i == swap_at);
         step(e_i, 8'(p + off), 1'b0);
         cfg_swap = 1'b0;
         if (gap_every > 0 && (i % gap_every) == gap_every - 1 && i != DEPTH - 1) begin
            idle(3);
         end
      end
      din_valid = 1'b0;
   endtask

   initial begin
      n_vec = 0; n_err = 0; n_step = 0;
      p_v = 1'b0; p_i = 8'h00; p_p = 8'h00;
      for (int k = 0; k < 256; k++) begin
         off0[k] = 8'h00; off1[k] = 8'h00; msk0[k] = 1'b0; msk1[k] = 1'b0;
      end
      din_valid = 1'b0; intensity_in = 8'h00; phase_in = 8'h00;
      cfg_we = 1'b0; cfg_addr = 8'h00; cfg_wdata = 9'h000; cfg_swap = 1'b0;

      // Reset with config activity that must be ignored
      rst = 1'b1; cfg_we = 1'b1; cfg_addr = 8'd0; cfg_wdata = 9'h1FF; cfg_swap = 1'b1;
      for (int k = 0; k < 3; k++) step(8'h00, 8'h00, 1'b0);
      rst = 1'b0; cfg_we = 1'b0; cfg_swap = 1'b0;
      idle(3);

      // Pass-through frame on zeroed bank 0
      run_frame(0, 8'h80, -1, 0, -1, DEPTH);
      idle(2);

      // Configure bank 1, swap; a write in the swap cycle lands in pre-swap shadow
      cfg_write(8'd5, 9'h0F0, 1'b0); off1[5] = 8'hF0;
      cfg_write(8'd6, 9'h1AB, 1'b0); off1[6] = 8'hAB; msk1[6] = 1'b1;
      cfg_swap = 1'b1; step(8'h00, 8'h00, 1'b0); cfg_swap = 1'b0;
      cfg_write(8'd7, 9'h005, 1'b1); off1[7] = 8'h05;
      idle(1);
      run_frame(1, 8'hFF, 8'h20, 0, -1, DEPTH);
      idle(2);

      // Mid-frame swap request: frame stays on bank 1, swap in first idle cycle
      cfg_write(8'd10, 9'h040, 1'b0); off0[10] = 8'h40;
      idle(1);
      run_frame(1, 8'h55, -1, 0, 100, DEPTH);
      step(8'h00, 8'h00, 1'b1);
      idle(2);
      run_frame(0, 8'h33, -1, 0, -1, DEPTH);
      idle(2);

      // Request right before a frame start, plus in-frame gaps: no swap until frame end
      cfg_swap = 1'b1; step(8'h00, 8'h00, 1'b0); cfg_swap = 1'b0;
      run_frame(0, 8'h77, 8'h90, 50, -1, DEPTH);
      step(8'h00, 8'h00, 1'b1);
      idle(1);

      // Reset at index 120 of a bank-1 frame
      run_frame(1, 8'h44, -1, 0, -1, 120);
      rst = 1'b1; din_valid = 1'b1; intensity_in = 8'h44; phase_in = 8'd120; cfg_swap = 1'b1;
      step(8'h00, 8'h00, 1'b0);
      rst = 1'b0; din_valid = 1'b0; cfg_swap = 1'b0;
      idle(2);

      // Last in-range address and an out-of-range one into shadow bank 1
      cfg_write(8'd248, 9'h100, 1'b0); msk1[248] = 1'b1;
      cfg_write(8'd250, 9'h1FF, 1'b0);
      idle(1);
      run_frame(0, 8'hC3, -1, 0, -1, DEPTH);
      idle(2);
      cfg_swap = 1'b1; step(8'h00, 8'h00, 1'b0); cfg_swap = 1'b0;
      step(8'h00, 8'h00, 1'b1);
      idle(1);
      run_frame(1, 8'h3C, -1, 0, -1, DEPTH);
      idle(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
